// File: rtl/nanov_spi_pkg.sv
// rtl/nanov_spi_pkg.sv - shared types and constants for the nanov SPI bus arbiter
//
// Purpose: FSM state encoding, SPI command bytes and a byte-order helper used by
// nanov_spi_arbiter and nanov_spi_shift.
// Optional feature macro: SPI_FAST_READ_EN adds the DUMMY state and the 0x0B
// fast-read command; without it reads use 0x03 and there is no DUMMY state.

package nanov_spi_pkg;

  localparam int         CMD_BITS      = 8;
  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] SPI_CMD_RD        = SPI_CMD_FAST_READ;
  localparam int         DUMMY_BITS        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DESEL
  } spi_state_e;
`else
  localparam logic [7:0] SPI_CMD_RD = SPI_CMD_READ;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DESEL
  } spi_state_e;
`endif

  // Reorders a little-endian word so an MSB-first shift emits byte 0 first.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/nanov_spi_shift.sv
// rtl/nanov_spi_shift.sv - loadable 32-bit serialiser with 6-bit down-counter
//
// Purpose: holds the word currently being sent on MOSI and counts the bits left
// in the current FSM phase.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   load        load load_data (optionally byte-swapped) and load_cnt
//   load_swap   byte-reverse load_data so byte 0 goes out first
//   shift_en    shift left one bit and decrement the counter
//   serial_in   bit shifted into the LSB
//   load_data   word to serialise, MSB first
//   load_cnt    bits in the phase minus one
//   serial_out  current MSB
//   cnt_zero    the current bit is the last of the phase

module nanov_spi_shift
  import nanov_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        load_swap,
  input  logic        shift_en,
  input  logic        serial_in,
  input  logic [31:0] load_data,
  input  logic [5:0]  load_cnt,
  output logic        serial_out,
  output logic        cnt_zero
);

  logic [31:0] sr_q, sr_d;
  logic [5:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = load_swap ? byte_swap32(load_data) : load_data;
      cnt_d = load_cnt;
    end else if (shift_en) begin
      sr_d  = {sr_q[30:0], serial_in};
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign serial_out = sr_q[31];
  assign cnt_zero   = (cnt_q == 6'd0);

endmodule

// File: rtl/nanov_spi_arbiter.sv
// rtl/nanov_spi_arbiter.sv - SPI memory bus arbiter for fetch and load/store
//
// Purpose: owns the SPI RAM/flash bus, grants it to data (priority) or fetch,
// serialises command/address/store data and flags returned data bits.
// Optional feature macro: SPI_FAST_READ_EN (0x0B reads with 8 dummy cycles).
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   ifetch_req/addr                fetch stream request and start address
//   ifetch_gnt/bit_valid/word_done fetch ownership, data bit strobe, word pulse
//   data_req/write/len/addr/wdata  load/store request (len = bytes-1)
//   data_gnt/bit_valid/done        data ownership, load bit strobe, last bit
//   spi_select/clk_enable/out      chip select (low), clock gate, MOSI
//   spi_data_in                    MISO

module nanov_spi_arbiter
  import nanov_spi_pkg::*;
#(
  parameter int ADDR_BITS = 24,
  parameter int MIN_DESEL = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ifetch_req,
  input  logic [ADDR_BITS-1:0] ifetch_addr,
  output logic                 ifetch_gnt,
  output logic                 ifetch_bit_valid,
  output logic                 ifetch_word_done,
  input  logic                 data_req,
  input  logic                 data_write,
  input  logic [1:0]           data_len,
  input  logic [ADDR_BITS-1:0] data_addr,
  input  logic [31:0]          data_wdata,
  output logic                 data_gnt,
  output logic                 data_bit_valid,
  output logic                 data_done,
  output logic                 spi_select,
  output logic                 spi_clk_enable,
  output logic                 spi_out,
  input  logic                 spi_data_in
);

  localparam logic [5:0] CMD_CNT   = 6'(CMD_BITS - 1);
  localparam logic [5:0] ADDR_CNT  = 6'(ADDR_BITS - 1);
  localparam logic [5:0] DESEL_CNT = 6'(MIN_DESEL - 1);

  spi_state_e           state_q, state_d;
  logic                 owner_data_q, owner_data_d;
  logic                 write_q, write_d;
  logic [1:0]           len_q, len_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [4:0]           fetch_cnt_q, fetch_cnt_d;
  logic                 word_done_q, word_done_d;

  logic        sh_load, sh_swap, sh_shift, sh_msb, sh_zero;
  logic [31:0] sh_data;
  logic [5:0]  sh_cnt, data_cnt;
  logic        busy, fetch_abort, enter_data, enter_desel;

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DESEL);
  assign fetch_abort = busy && !owner_data_q && !ifetch_req;
  // Data phase length: 8*(len+1)-1; the fetch stream is unbounded and uses fetch_cnt instead.
  assign data_cnt    = owner_data_q ? {1'b0, len_q, 3'b111} : 6'd31;

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    write_d      = write_q;
    len_d        = len_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    fetch_cnt_d  = fetch_cnt_q;
    word_done_d  = 1'b0;
    sh_load      = 1'b0;
    sh_swap      = 1'b0;
    sh_shift     = 1'b0;
    sh_data      = '0;
    sh_cnt       = '0;
    enter_data   = 1'b0;
    enter_desel  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_req) begin
          state_d      = ST_CMD;
          owner_data_d = 1'b1;
          write_d      = data_write;
          len_d        = (data_len == 2'd2) ? 2'd3 : data_len;
          addr_d       = data_addr;
          wdata_d      = data_wdata;
          sh_load      = 1'b1;
          sh_data      = {(data_write ? SPI_CMD_WRITE : SPI_CMD_RD), 24'h0};
          sh_cnt       = CMD_CNT;
        end else if (ifetch_req) begin
          state_d      = ST_CMD;
          owner_data_d = 1'b0;
          write_d      = 1'b0;
          addr_d       = ifetch_addr;
          sh_load      = 1'b1;
          sh_data      = {SPI_CMD_RD, 24'h0};
          sh_cnt       = CMD_CNT;
        end
      end
      ST_CMD: begin
        sh_shift = 1'b1;
        if (fetch_abort) begin
          enter_desel = 1'b1;
        end else if (sh_zero) begin
          state_d = ST_ADDR;
          sh_load = 1'b1;
          sh_data = 32'(addr_q) << (32 - ADDR_BITS);
          sh_cnt  = ADDR_CNT;
        end
      end
      ST_ADDR: begin
        sh_shift = 1'b1;
        if (fetch_abort) begin
          enter_desel = 1'b1;
        end else if (sh_zero) begin
`ifdef SPI_FAST_READ_EN
          if (!write_q) begin
            state_d = ST_DUMMY;
            sh_load = 1'b1;
            sh_cnt  = 6'(DUMMY_BITS - 1);
          end else begin
            enter_data = 1'b1;
          end
`else
          enter_data = 1'b1;
`endif
        end
      end
`ifdef SPI_FAST_READ_EN
      ST_DUMMY: begin
        sh_shift = 1'b1;
        if (fetch_abort) begin
          enter_desel = 1'b1;
        end else if (sh_zero) begin
          enter_data = 1'b1;
        end
      end
`endif
      ST_DATA: begin
        if (owner_data_q) begin
          sh_shift = 1'b1;
          if (sh_zero) begin
            enter_desel = 1'b1;
          end
        end else begin
          fetch_cnt_d = fetch_cnt_q + 5'd1;
          word_done_d = (fetch_cnt_q == 5'd31);
          // A pending load/store only takes the bus once the current word is complete.
          if (!ifetch_req || (data_req && (fetch_cnt_q == 5'd31))) begin
            enter_desel = 1'b1;
          end
        end
      end
      ST_DESEL: begin
        if (sh_zero) begin
          state_d = ST_IDLE;
        end else begin
          sh_shift = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_desel) begin
      state_d = ST_DESEL;
      sh_load = 1'b1;
      sh_data = '0;
      sh_cnt  = DESEL_CNT;
    end
    if (enter_data) begin
      state_d     = ST_DATA;
      sh_load     = 1'b1;
      sh_swap     = 1'b1;
      sh_data     = wdata_q;
      sh_cnt      = data_cnt;
      fetch_cnt_d = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      owner_data_q <= 1'b0;
      write_q      <= 1'b0;
      len_q        <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fetch_cnt_q  <= 5'd0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      write_q      <= write_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      fetch_cnt_q  <= fetch_cnt_d;
      word_done_q  <= word_done_d;
    end
  end

  nanov_spi_shift u_shift (
    .clk        (clk),
    .rstn       (rstn),
    .load       (sh_load),
    .load_swap  (sh_swap),
    .shift_en   (sh_shift),
    .serial_in  (spi_data_in),
    .load_data  (sh_data),
    .load_cnt   (sh_cnt),
    .serial_out (sh_msb),
    .cnt_zero   (sh_zero)
  );

  assign spi_select       = !busy;
  assign spi_clk_enable   = busy;
  assign spi_out          = ((state_q == ST_CMD) || (state_q == ST_ADDR) ||
                             ((state_q == ST_DATA) && write_q)) && sh_msb;
  assign ifetch_gnt       = busy && !owner_data_q;
  assign data_gnt         = busy && owner_data_q;
  assign ifetch_bit_valid = (state_q == ST_DATA) && !owner_data_q;
  assign data_bit_valid   = (state_q == ST_DATA) && owner_data_q && !write_q;
  assign data_done        = (state_q == ST_DATA) && owner_data_q && sh_zero;
  assign ifetch_word_done = word_done_q;

endmodule

// File: tb/tb_nanov_spi_arbiter.sv
// tb/tb_nanov_spi_arbiter.sv - scoreboard bench for nanov_spi_arbiter

module tb_nanov_spi_arbiter;

`ifdef SPI_FAST_READ_EN
  localparam int         DUMMY  = 8;
  localparam logic [7:0] RD_CMD = 8'h0B;
`else
  localparam int         DUMMY  = 0;
  localparam logic [7:0] RD_CMD = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ifetch_req = 1'b0;
  logic [23:0] ifetch_addr = '0;
  logic        ifetch_gnt, ifetch_bit_valid, ifetch_word_done;
  logic        data_req = 1'b0;
  logic        data_write = 1'b0;
  logic [1:0]  data_len = '0;
  logic [23:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_gnt, data_bit_valid, data_done;
  logic        spi_select, spi_clk_enable, spi_out;
  logic        spi_data_in = 1'b0;

  always #5 clk = ~clk;

  nanov_spi_arbiter #(.ADDR_BITS(24), .MIN_DESEL(1)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .ifetch_req       (ifetch_req),
    .ifetch_addr      (ifetch_addr),
    .ifetch_gnt       (ifetch_gnt),
    .ifetch_bit_valid (ifetch_bit_valid),
    .ifetch_word_done (ifetch_word_done),
    .data_req         (data_req),
    .data_write       (data_write),
    .data_len         (data_len),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .data_gnt         (data_gnt),
    .data_bit_valid   (data_bit_valid),
    .data_done        (data_done),
    .spi_select       (spi_select),
    .spi_clk_enable   (spi_clk_enable),
    .spi_out          (spi_out),
    .spi_data_in      (spi_data_in)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    bit          chk_addr;
    bit          chk_len;
    int          en;
    int          fval;
    int          dval;
    int          wdone;
    int          ddone;
    int          wd_first;
    int          wd_gap;
    bit          chk_wdata;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   overlap = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] cmd, input logic [23:0] addr, input bit chk_addr,
                      input bit chk_len, input int en, input int fval, input int dval,
                      input int wdone, input int ddone, input int wd_first, input int wd_gap,
                      input bit chk_wdata, input logic [31:0] wdata);
    exp_t e;
    e.cmd = cmd; e.addr = addr; e.chk_addr = chk_addr; e.chk_len = chk_len;
    e.en = en; e.fval = fval; e.dval = dval; e.wdone = wdone; e.ddone = ddone;
    e.wd_first = wd_first; e.wd_gap = wd_gap; e.chk_wdata = chk_wdata; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(negedge clk);
    spi_data_in = 1'($urandom_range(0, 1));
  end

  // Monitor: accumulates one bus transaction per select-low window and
  // checks it against the next scoreboard entry when select returns high.
  initial begin
    bit          in_txn;
    int          m_en, m_low, m_fval, m_dval, m_wd, m_dd, m_wd1, m_wd2;
    logic [7:0]  m_cmd;
    logic [23:0] m_addr;
    logic [31:0] m_wdat;
    exp_t        e;
    in_txn = 0; m_en = 0; m_low = 0; m_fval = 0; m_dval = 0; m_wd = 0; m_dd = 0;
    m_wd1 = 0; m_wd2 = 0; m_cmd = '0; m_addr = '0; m_wdat = '0;
    forever begin
      @(negedge clk);
      if (ifetch_gnt && data_gnt) overlap++;
      if (!spi_select || in_txn) begin
        in_txn = 1;
        if (!spi_select) m_low++;
        if (spi_clk_enable) begin
          if (m_en < 8) m_cmd = {m_cmd[6:0], spi_out};
          else if (m_en < 32) m_addr = {m_addr[22:0], spi_out};
          else if (m_en < 64) m_wdat = {m_wdat[30:0], spi_out};
          m_en++;
        end
        if (ifetch_bit_valid) m_fval++;
        if (data_bit_valid) m_dval++;
        if (data_done) m_dd++;
        if (ifetch_word_done) begin
          m_wd++;
          if (m_wd == 1) m_wd1 = m_fval;
          else if (m_wd == 2) m_wd2 = m_fval;
        end
        if (spi_select) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_txn: got cmd %0h expected no transaction", m_cmd);
          end else begin
            e = exp_q.pop_front();
            chk("cmd", int'(m_cmd), int'(e.cmd));
            if (e.chk_addr) chk("addr", int'(m_addr), int'(e.addr));
            if (e.chk_len) begin
              chk("clk_en_cycles", m_en, e.en);
              chk("sel_low_cycles", m_low, e.en);
              chk("fetch_valid", m_fval, e.fval);
              chk("data_valid", m_dval, e.dval);
              chk("word_done", m_wd, e.wdone);
              chk("data_done", m_dd, e.ddone);
              if (e.wdone > 0) chk("word_done_pos", m_wd1, e.wd_first);
              if (e.wdone > 1) chk("word_done_gap", m_wd2 - m_wd1, e.wd_gap);
              if (e.chk_wdata) chk("wdata_stream", int'(m_wdat), int'(e.wdata));
            end
          end
          in_txn = 0; m_en = 0; m_low = 0; m_fval = 0; m_dval = 0; m_wd = 0; m_dd = 0;
          m_wd1 = 0; m_wd2 = 0; m_cmd = '0; m_addr = '0; m_wdat = '0;
        end
      end
    end
  end

  task automatic wait_data_done();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      seen = data_done;
    end
    chk("data_done_seen", int'(seen), 1);
    @(posedge clk); #1;
    data_req = 1'b0;
    ifetch_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic data_txn(input bit wr, input logic [1:0] len, input logic [23:0] addr,
                          input logic [31:0] wd);
    data_write = wr; data_len = len; data_addr = addr; data_wdata = wd;
    data_req = 1'b1;
    wait_data_done();
  endtask

  initial begin
    int n;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_select", int'(spi_select), 1);
    chk("rst_clk_enable", int'(spi_clk_enable), 0);
    chk("rst_spi_out", int'(spi_out), 0);
    chk("rst_ifetch_gnt", int'(ifetch_gnt), 0);
    chk("rst_data_gnt", int'(data_gnt), 0);
    chk("rst_valids", int'({ifetch_bit_valid, data_bit_valid}), 0);
    chk("rst_pulses", int'({ifetch_word_done, data_done}), 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Fetch stream from 0x000100, dropped right after the second word pulse.
    push(RD_CMD, 24'h000100, 1, 1, 97 + DUMMY, 65, 0, 2, 0, 33, 32, 0, '0);
    ifetch_addr = 24'h000100;
    ifetch_req = 1'b1;
    n = 0;
    for (int i = 0; i < 400 && n < 2; i++) begin
      @(posedge clk); #1;
      if (ifetch_word_done) n++;
    end
    chk("fetch_two_words_seen", n, 2);
    ifetch_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Word store: bytes go out 81, 0F, C3, A5.
    push(8'h02, 24'h001234, 1, 1, 64, 0, 0, 0, 1, 0, 0, 1, 32'h810F_C3A5);
    data_txn(1'b1, 2'd3, 24'h001234, 32'hA5C3_0F81);

    // Data request 10 bits into a fetch word: fetch completes the word first.
    push(RD_CMD, 24'h000200, 1, 1, 64 + DUMMY, 32, 0, 1, 0, 32, 0, 0, '0);
    push(RD_CMD, 24'h000040, 1, 1, 48 + DUMMY, 0, 16, 0, 1, 0, 0, 0, '0);
    ifetch_addr = 24'h000200;
    ifetch_req = 1'b1;
    n = 0;
    for (int i = 0; i < 400 && n < 10; i++) begin
      @(posedge clk); #1;
      if (ifetch_bit_valid) n++;
    end
    data_write = 1'b0; data_len = 2'd1; data_addr = 24'h000040;
    data_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = data_gnt;
    end
    chk("preempt_data_gnt_seen", int'(seen), 1);
    ifetch_req = 1'b0;
    wait_data_done();

    // Branch abort 5 bits into the address phase.
    push(RD_CMD, 24'h000300, 0, 1, 13, 0, 0, 0, 0, 0, 0, 0, '0);
    ifetch_addr = 24'h000300;
    ifetch_req = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 13; i++) begin
      @(posedge clk); #1;
      if (spi_clk_enable) n++;
    end
    ifetch_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Byte load, then a len=2 load that runs as a full word.
    push(RD_CMD, 24'h000700, 1, 1, 40 + DUMMY, 0, 8, 0, 1, 0, 0, 0, '0);
    data_txn(1'b0, 2'd0, 24'h000700, 32'h0);
    push(RD_CMD, 24'h000800, 1, 1, 64 + DUMMY, 0, 32, 0, 1, 0, 0, 0, '0);
    data_txn(1'b0, 2'd2, 24'h000800, 32'h0);

    // Simultaneous requests in IDLE: the byte store wins.
    push(8'h02, 24'h000900, 1, 1, 40, 0, 0, 0, 1, 0, 0, 1, 32'h0000_005A);
    ifetch_addr = 24'h000A00;
    ifetch_req = 1'b1;
    data_txn(1'b1, 2'd0, 24'h000900, 32'h1122_335A);

    // Asynchronous reset in the middle of a load's data phase.
    push(RD_CMD, 24'h000500, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    data_write = 1'b0; data_len = 2'd3; data_addr = 24'h000500;
    data_req = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 5; i++) begin
      @(posedge clk); #1;
      if (data_bit_valid) n++;
    end
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_select", int'(spi_select), 1);
    chk("async_rst_clk_enable", int'(spi_clk_enable), 0);
    chk("async_rst_data_gnt", int'(data_gnt), 0);
    data_req = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_select", int'(spi_select), 1);
    chk("post_rst_clk_enable", int'(spi_clk_enable), 0);
    chk("post_rst_gnts", int'({ifetch_gnt, data_gnt}), 0);
    chk("post_rst_spi_out", int'(spi_out), 0);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
    chk("queue_drain", exp_q.size(), 0);
    chk("gnt_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
